// File: rtl/jtcontra_snd_latch.sv
// Sound-command latch between the main CPU and the sound CPU.
// The main CPU writes a byte on each rising edge of snd_irq. The sound CPU
// reads it through rd_cs and gets an active-low interrupt while data waits.
//
// Build option JTCONTRA_LATCH_FIFO_EN:
//   defined   -> 2**DEPTH_LOG2-entry FIFO; when full, a new byte is dropped
//                and overflow is flagged.
//   undefined -> single register; a new byte overwrites any unread byte.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   snd_cen        sound-CPU bus-cycle enable; qualifies rd_cs/irq_ack/ovf_clr
//   snd_irq        command strobe; a rising edge pushes snd_latch
//   snd_latch[7:0] command byte
//   rd_cs          sound-CPU read of the latch (pop)
//   irq_ack        interrupt acknowledge
//   ovf_clr        clears the sticky overflow flag
//   latch_dout     head entry, or the last popped byte when empty
//   irqn           registered active-low interrupt
//   pending        number of unread entries
//   overflow       sticky: a command was lost
module jtcontra_snd_latch #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  snd_cen,
  input  logic                  snd_irq,
  input  logic [7:0]            snd_latch,
  input  logic                  rd_cs,
  input  logic                  irq_ack,
  input  logic                  ovf_clr,
  output logic [7:0]            latch_dout,
  output logic                  irqn,
  output logic [DEPTH_LOG2:0]   pending,
  output logic                  overflow
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;

  logic          snd_irq_q;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          lost;
  logic          irq_set;
  logic [PW-1:0] pending_nxt;

  // snd_irq_q resets high so a strobe already high at reset release is not a write
  assign push = snd_irq & ~snd_irq_q;
  assign pop  = rd_cs & snd_cen & (pending != '0);

`ifdef JTCONTRA_LATCH_FIFO_EN
  localparam int unsigned DEPTH = 2**DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [7:0]            last_q;
  logic                  full;

  // A same-cycle pop frees a slot, so a full FIFO still accepts the push
  assign full        = (pending == PW'(DEPTH));
  assign wr_en       = push & (~full | pop);
  assign lost        = push & full & ~pop;
  assign pending_nxt = pending + PW'(wr_en) - PW'(pop);

  // Storage needs no reset: entries are only visible through pending
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= snd_latch;
  end

  // Pointers, plus the byte shown once the FIFO drains
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        last_q <= mem[rd_ptr];
      end
    end
  end

  assign latch_dout = (pending != '0) ? mem[rd_ptr] : last_q;
`else
  logic [7:0] data_q;

  // Every push overwrites; it is a loss only if the old byte was unread and not popped now
  assign wr_en       = push;
  assign lost        = push & (pending != '0) & ~pop;
  assign pending_nxt = PW'(push | ((pending != '0) & ~pop));

  // The register keeps the last byte after a pop, so it drives the bus directly
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) data_q <= '0;
    else if (wr_en) data_q <= snd_latch;
  end

  assign latch_dout = data_q;
`endif

  assign irq_set = wr_en | (pop & (pending_nxt != '0));

  // Occupancy, sticky overflow and interrupt; a set beats a same-cycle clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snd_irq_q <= 1'b1;
      pending   <= '0;
      overflow  <= 1'b0;
      irqn      <= 1'b1;
    end else begin
      snd_irq_q <= snd_irq;
      pending   <= pending_nxt;
      if (lost) overflow <= 1'b1;
      else if (ovf_clr & snd_cen) overflow <= 1'b0;
      if (irq_set) irqn <= 1'b0;
      else if (irq_ack & snd_cen) irqn <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtcontra_snd_latch.sv
// Bench for jtcontra_snd_latch. A queue-based reference model predicts the
// outputs after each clock; a monitor process compares them with the DUT.
module tb_jtcontra_snd_latch;

  localparam int unsigned DL2 = 2;
  localparam int unsigned PW  = DL2 + 1;
`ifdef JTCONTRA_LATCH_FIFO_EN
  localparam int DEPTH = 1 << DL2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          snd_cen = 1'b0;
  logic          snd_irq = 1'b0;
  logic [7:0]    snd_latch = 8'h00;
  logic          rd_cs = 1'b0;
  logic          irq_ack = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [7:0]    latch_dout;
  logic          irqn;
  logic [PW-1:0] pending;
  logic          overflow;

  jtcontra_snd_latch #(.DEPTH_LOG2(DL2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .snd_cen    (snd_cen),
    .snd_irq    (snd_irq),
    .snd_latch  (snd_latch),
    .rd_cs      (rd_cs),
    .irq_ack    (irq_ack),
    .ovf_clr    (ovf_clr),
    .latch_dout (latch_dout),
    .irqn       (irqn),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    dout;
    logic [PW-1:0] pend;
    logic          ovf;
    logic          irqn;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_last;
  bit         m_prev;
  bit         m_ovf;
  bit         m_irq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 8'h00;
    m_prev = 1'b1;
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
  endtask

  // One clock of the command channel, expressed as queue operations
  task automatic model_step(input bit irq, input logic [7:0] d, input bit rd,
                            input bit cen, input bit ack, input bit clr);
    bit   psh;
    bit   pp;
    bit   acc;
    bit   lst;
    exp_t e;
    psh = irq && !m_prev;
    m_prev = irq;
    pp  = rd && cen && (mq.size() > 0);
    acc = 1'b0;
    lst = 1'b0;
    if (pp) m_last = mq.pop_front();
    if (psh) begin
`ifdef JTCONTRA_LATCH_FIFO_EN
      if (mq.size() < DEPTH) begin
        mq.push_back(d);
        acc = 1'b1;
      end else begin
        lst = 1'b1;
      end
`else
      if (mq.size() != 0) begin
        lst = 1'b1;
        mq.delete();
      end
      mq.push_back(d);
      acc = 1'b1;
`endif
    end
    if (lst) m_ovf = 1'b1;
    else if (clr && cen) m_ovf = 1'b0;
    if (acc || (pp && mq.size() > 0)) m_irq = 1'b1;
    else if (ack && cen) m_irq = 1'b0;
    e.dout = (mq.size() > 0) ? mq[0] : m_last;
    e.pend = PW'(mq.size());
    e.ovf  = m_ovf;
    e.irqn = ~m_irq;
    sb.push_back(e);
  endtask

  task automatic apply(input bit irq, input logic [7:0] d, input bit rd,
                       input bit cen, input bit ack, input bit clr);
    snd_irq = irq; snd_latch = d; rd_cs = rd; snd_cen = cen;
    irq_ack = ack; ovf_clr = clr;
    model_step(irq, d, rd, cen, ack, clr);
  endtask

  task automatic drive(input bit irq, input logic [7:0] d, input bit rd,
                       input bit cen, input bit ack, input bit clr);
    @(negedge clk);
    apply(irq, d, rd, cen, ack, clr);
  endtask

  task automatic push_b(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_b();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit irq_hi);
    @(negedge clk);
    rstn = 1'b0;
    snd_irq = irq_hi; rd_cs = 1'b0; snd_cen = 1'b0; irq_ack = 1'b0; ovf_clr = 1'b0;
    #1;
    chk("rst_dout", latch_dout, 8'h00);
    chk("rst_irqn", irqn, 1'b1);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    apply(irq_hi, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the next predicted set after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rstn && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_dout", latch_dout, e.dout);
        chk("sb_pending", pending, e.pend);
        chk("sb_overflow", overflow, e.ovf);
        chk("sb_irqn", irqn, e.irqn);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_rd [4];
    model_reset();
    do_reset(1'b0);

    // First write after reset
    push_b(8'h5A);
    settle();
    chk("first_pending", pending, 1);
    chk("first_irqn", irqn, 1'b0);
    chk("first_dout", latch_dout, 8'h5A);
    pop_b();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("empty_read_dout", latch_dout, 8'h5A);
    chk("empty_read_pending", pending, 0);

    // Acknowledge with data waiting, then pop
    push_b(8'h11);
    push_b(8'h22);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("ack_irqn", irqn, 1'b1);
    pop_b();
    settle();
`ifdef JTCONTRA_LATCH_FIFO_EN
    chk("ackpop_pending", pending, 1);
    chk("ackpop_irqn", irqn, 1'b0);
`else
    chk("ackpop_pending", pending, 0);
    chk("ackpop_irqn", irqn, 1'b1);
`endif
    pop_b();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

`ifdef JTCONTRA_LATCH_FIFO_EN
    // Overfill, then drain
    for (int i = 1; i <= 5; i++) push_b(8'(i));
    settle();
    chk("ovf_pending", pending, 4);
    chk("ovf_flag", overflow, 1'b1);
    exp_rd[0] = 8'h01; exp_rd[1] = 8'h02; exp_rd[2] = 8'h03; exp_rd[3] = 8'h04;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) settle();
      chk("drain_dout", latch_dout, exp_rd[i]);
      pop_b();
    end
    settle();
    chk("drain_hold", latch_dout, 8'h04);
    chk("drain_pending", pending, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

    // Push and pop together while full
    push_b(8'h10); push_b(8'h20); push_b(8'h30); push_b(8'h40);
    drive(1'b1, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("full_pp_pending", pending, 4);
    chk("full_pp_ovf", overflow, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) pop_b();
    settle();
    chk("full_pp_last", latch_dout, 8'h50);
    pop_b();
`else
    // Overwrite an unread byte
    push_b(8'hAA);
    push_b(8'hBB);
    settle();
    chk("ovw_dout", latch_dout, 8'hBB);
    chk("ovw_pending", pending, 1);
    chk("ovw_ovf", overflow, 1'b1);
    drive(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("ovw_pp_ovf", overflow, 1'b0);
    chk("ovw_pp_dout", latch_dout, 8'hCC);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_b();
`endif

    // Strobe held high across reset release
    do_reset(1'b1);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("hold_pending", pending, 0);
    chk("hold_irqn", irqn, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of traffic
    push_b(8'h3C);
    do_reset(1'b0);
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 1) == 0), 8'($urandom), ($urandom_range(0, 3) == 0),
            1'b1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    settle();
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
